// File: rtl/ej32_prefetch.sv
// eJ32 instruction prefetch queue: streams bytes from synchronous program
// memory into a small FIFO and presents the head byte with its address.
// A flush (or reset) empties the queue and restarts fetching at a new target.
module ej32_prefetch #(
  parameter int ASZ   = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_re,
  output logic [ASZ-1:0]           mem_addr,
  input  logic [7:0]               mem_data,
  input  logic                     hold,
  input  logic                     flush,
  input  logic [ASZ-1:0]           flush_addr,
  input  logic                     pop,
  output logic                     valid_o,
  output logic [7:0]               byte_o,
  output logic [ASZ-1:0]           pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]  r_hp;
  logic [PW-1:0]  r_tp;
  logic [CW-1:0]  r_cnt;
  logic [ASZ-1:0] r_fa;
  logic [ASZ-1:0] r_pc;
  logic           r_inf;

  logic [CW-1:0]  w_occ;
  logic           w_issue;
  logic           w_pop;
  logic           w_wr;
  logic [7:0]     w_ent [DEPTH];

  // Occupancy counts the in-flight byte so a full queue can never overflow.
  assign w_occ   = r_cnt + {{(CW-1){1'b0}}, r_inf};
  assign w_issue = !hold && !flush && !rst && (w_occ < DEPTH_C);
  assign w_pop   = pop && (r_cnt != '0);
  assign w_wr    = r_inf && !flush;

  assign mem_re   = w_issue;
  assign mem_addr = w_issue ? r_fa : '0;

  // One register per FIFO slot; the returning byte lands at the tail slot.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [7:0] r_byte;
      // Slot write on returning read; cleared by reset so byte_o starts at 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_byte <= '0;
        end else if (w_wr && (r_tp == PW'(gi))) begin
          r_byte <= mem_data;
        end
      end
      assign w_ent[gi] = r_byte;
    end
  endgenerate

  // Pointers, count, fetch/head addresses; flush and reset win over all else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hp  <= '0;
      r_tp  <= '0;
      r_cnt <= '0;
      r_inf <= 1'b0;
      r_fa  <= '0;
      r_pc  <= '0;
    end else if (flush) begin
      r_hp  <= '0;
      r_tp  <= '0;
      r_cnt <= '0;
      r_inf <= 1'b0;
      r_fa  <= flush_addr;
      r_pc  <= flush_addr;
    end else begin
      if (r_inf) begin
        r_tp <= r_tp + 1'b1;
      end
      if (w_pop) begin
        r_hp <= r_hp + 1'b1;
        r_pc <= r_pc + 1'b1;
      end
      case ({r_inf, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_inf <= w_issue;
      if (w_issue) begin
        r_fa <= r_fa + 1'b1;
      end
    end
  end

  assign valid_o = (r_cnt != '0);
  assign byte_o  = w_ent[r_hp];
  assign pc_o    = r_pc;
  assign count_o = r_cnt;

endmodule

// File: tb/tb_ej32_prefetch.sv
// Self-checking bench for ej32_prefetch: a queue-based model of the prefetch
// behaviour checked every cycle, plus hand-computed expectations per scenario.
module tb_ej32_prefetch;

  localparam int ASZ   = 17;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << ASZ) - 1;

  logic           clk;
  logic           rst;
  logic           mem_re;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_data;
  logic           hold;
  logic           flush;
  logic [ASZ-1:0] flush_addr;
  logic           pop;
  logic           valid_o;
  logic [7:0]     byte_o;
  logic [ASZ-1:0] pc_o;
  logic [2:0]     count_o;

  int n_chk  = 0;
  int n_pass = 0;

  ej32_prefetch #(.ASZ(ASZ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .hold      (hold),
    .flush     (flush),
    .flush_addr(flush_addr),
    .pop       (pop),
    .valid_o   (valid_o),
    .byte_o    (byte_o),
    .pc_o      (pc_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: mem[i] = i[7:0], data one cycle after the strobe.
  initial mem_data = 8'h00;
  always @(posedge clk) mem_data <= mem_re ? mem_addr[7:0] : 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Model: queue of byte addresses held, plus the fetch pointer and the
  // address of the read (if any) that is currently out at memory.
  int m_q[$];
  int m_fa = 0;
  int m_pc = 0;
  int m_inf_addr = 0;
  bit m_inf = 0;
  bit m_ok = 0;

  function automatic bit exp_re();
    return !hold && !flush && !rst && ((m_q.size() + int'(m_inf)) < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit issue;
    bit popv;
    if (rst) begin
      m_q.delete();
      m_fa = 0; m_pc = 0; m_inf = 0;
      m_ok = 1;
    end else if (flush) begin
      m_q.delete();
      m_inf = 0;
      m_fa = int'(flush_addr);
      m_pc = int'(flush_addr);
    end else begin
      issue = exp_re();
      popv  = pop && (m_q.size() != 0);
      if (popv) begin
        void'(m_q.pop_front());
        m_pc = (m_pc + 1) & MASK;
      end
      if (m_inf) m_q.push_back(m_inf_addr);
      if (issue) begin
        m_inf_addr = m_fa;
        m_fa = (m_fa + 1) & MASK;
        m_inf = 1;
      end else begin
        m_inf = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("mem_re", int'(mem_re), int'(exp_re()));
      if (exp_re()) chk("mem_addr", int'(mem_addr), m_fa);
      chk("valid_o", int'(valid_o), int'(m_q.size() != 0));
      chk("count_o", int'(count_o), m_q.size());
      chk("pc_o", int'(pc_o), m_pc);
      if (m_q.size() != 0) begin
        chk("byte_o", int'(byte_o), m_q[0] & 255);
        if (pop && !flush && !rst)
          $display("pop  pc=0x%05h byte=0x%02h count=%0d", pc_o, byte_o, count_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; flush_addr = '0; pop = 1'b0;
    step(); step();
    // Reset state
    @(negedge clk);
    chk("rst mem_re", int'(mem_re), 0);
    chk("rst mem_addr", int'(mem_addr), 0);
    chk("rst valid_o", int'(valid_o), 0);
    chk("rst byte_o", int'(byte_o), 0);
    chk("rst pc_o", int'(pc_o), 0);
    chk("rst count_o", int'(count_o), 0);
    step(); rst = 1'b0;
    // First read in the first cycle after reset
    @(negedge clk);
    chk("first mem_re", int'(mem_re), 1);
    chk("first mem_addr", int'(mem_addr), 0);
    repeat (6) step();
    // Filled with no pop
    @(negedge clk);
    chk("fill count_o", int'(count_o), 4);
    chk("fill byte_o", int'(byte_o), 0);
    chk("fill pc_o", int'(pc_o), 0);
    chk("fill mem_re", int'(mem_re), 0);

    // Continuous pop stream
    step(); pop = 1'b1;
    repeat (12) step();
    pop = 1'b0;
    repeat (6) step();

    // Flush while a read is in flight with three bytes queued
    pop = 1'b1; step(); pop = 1'b0; step();
    flush = 1'b1; flush_addr = 17'h01234;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush count_o", int'(count_o), 0);
    chk("flush valid_o", int'(valid_o), 0);
    chk("flush re N+1", int'(mem_re), 1);
    chk("flush addr N+1", int'(mem_addr), 17'h01234);
    step();
    @(negedge clk);
    chk("flush valid N+2", int'(valid_o), 0);
    chk("flush addr N+2", int'(mem_addr), 17'h01235);
    step();
    @(negedge clk);
    chk("flush valid N+3", int'(valid_o), 1);
    chk("flush byte N+3", int'(byte_o), 8'h34);
    chk("flush pc N+3", int'(pc_o), 17'h01234);

    // Hold for 5 cycles mid-stream
    pop = 1'b1;
    repeat (3) step();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold mem_re", int'(mem_re), 0);
      step();
    end
    hold = 1'b0;
    repeat (8) step();
    pop = 1'b0;

    // Address wrap
    step();
    flush = 1'b1; flush_addr = 17'h1FFFF;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("wrap addr N+1", int'(mem_addr), 17'h1FFFF);
    step();
    @(negedge clk);
    chk("wrap addr N+2", int'(mem_addr), 0);
    step(); pop = 1'b1;
    @(negedge clk);
    chk("wrap pc 0", int'(pc_o), 17'h1FFFF);
    chk("wrap byte 0", int'(byte_o), 8'hFF);
    step();
    @(negedge clk);
    chk("wrap pc 1", int'(pc_o), 0);
    chk("wrap byte 1", int'(byte_o), 0);
    step();
    @(negedge clk);
    chk("wrap pc 2", int'(pc_o), 1);
    chk("wrap byte 2", int'(byte_o), 1);
    step(); pop = 1'b0;

    // Flush together with pop, then pop while empty
    step();
    flush = 1'b1; flush_addr = 17'h00100; pop = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("fpop count N+1", int'(count_o), 0);
    chk("fpop valid N+1", int'(valid_o), 0);
    step();
    @(negedge clk);
    chk("fpop count N+2", int'(count_o), 0);
    step();
    @(negedge clk);
    chk("fpop count N+3", int'(count_o), 1);
    chk("fpop pc N+3", int'(pc_o), 17'h00100);
    chk("fpop byte N+3", int'(byte_o), 0);
    step(); pop = 1'b0;
    repeat (4) step();

    // Reset mid-operation acts as flush to 0
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("mrst pc_o", int'(pc_o), 0);
    chk("mrst count_o", int'(count_o), 0);
    chk("mrst mem_re", int'(mem_re), 1);
    chk("mrst mem_addr", int'(mem_addr), 0);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
